// File: rtl/ddr_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_port_arbiter_if
// Purpose  : Client, Avalon-MM bridge and status signals of ddr_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_port_arbiter_if;
    logic         local_cal_success;

    logic         c0_req;
    logic         c0_we;
    logic [24:0]  c0_addr;
    logic [255:0] c0_wdata;
    logic [31:0]  c0_be;
    logic         c0_gnt;
    logic         c0_done;
    logic         c0_rvalid;
    logic [255:0] c0_rdata;

    logic         c1_req;
    logic         c1_we;
    logic [24:0]  c1_addr;
    logic [255:0] c1_wdata;
    logic [31:0]  c1_be;
    logic         c1_gnt;
    logic         c1_done;
    logic         c1_rvalid;
    logic [255:0] c1_rdata;

    logic         wr_rq;
    logic         rd_rq;
    logic [24:0]  wr_adr;
    logic [24:0]  rd_adr;
    logic [255:0] wr_data;
    logic [31:0]  byte_enable;
    logic         rd_valid;
    logic [255:0] rd_data;
    logic         action_done;

    logic         busy;
    logic         err;
    logic         timeout_err;

    // Arbiter side
    modport master (
        input  local_cal_success,
        input  c0_req, c0_we, c0_addr, c0_wdata, c0_be,
        output c0_gnt, c0_done, c0_rvalid, c0_rdata,
        input  c1_req, c1_we, c1_addr, c1_wdata, c1_be,
        output c1_gnt, c1_done, c1_rvalid, c1_rdata,
        output wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
        input  rd_valid, rd_data, action_done,
        output busy, err, timeout_err
    );

    // Clients and bridge side
    modport slave (
        output local_cal_success,
        output c0_req, c0_we, c0_addr, c0_wdata, c0_be,
        input  c0_gnt, c0_done, c0_rvalid, c0_rdata,
        output c1_req, c1_we, c1_addr, c1_wdata, c1_be,
        input  c1_gnt, c1_done, c1_rvalid, c1_rdata,
        input  wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
        output rd_valid, rd_data, action_done,
        input  busy, err, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_port_arbiter
// Purpose  : Two-client round-robin arbiter in front of a DDR Avalon-MM bridge.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                avalon_clk,
    input  logic                avalon_reset,
    ddr_port_arbiter_if.master  bus
);

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant;
    logic          w_timeout;
    logic          w_win_id;
    logic          w_win_we;
    logic [24:0]   w_win_addr;
    logic [255:0]  w_win_wdata;
    logic [31:0]   w_win_be;
    logic          w_capture;
    logic          w_enter_resp;
    logic          w_rvalid_nxt;

    logic          r_cur_id;
    logic          r_cur_we;
    logic          r_last_id;
    logic          r_rd_seen;
    logic [15:0]   r_cnt;
    logic          r_c0_gnt, r_c1_gnt;
    logic          r_c0_done, r_c1_done;
    logic          r_c0_rvalid, r_c1_rvalid;
    logic [255:0]  r_c0_rdata, r_c1_rdata;
    logic          r_wr_rq, r_rd_rq;
    logic [24:0]   r_wr_adr, r_rd_adr;
    logic [255:0]  r_wr_data;
    logic [31:0]   r_byte_enable;
    logic          r_busy, r_err, r_timeout_err;

    // Tie goes to the client that was not served last
    assign w_win_id    = (bus.c0_req && bus.c1_req) ? ~r_last_id : bus.c1_req;
    assign w_win_we    = w_win_id ? bus.c1_we    : bus.c0_we;
    assign w_win_addr  = w_win_id ? bus.c1_addr  : bus.c0_addr;
    assign w_win_wdata = w_win_id ? bus.c1_wdata : bus.c0_wdata;
    assign w_win_be    = w_win_id ? bus.c1_be    : bus.c0_be;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.local_cal_success && (bus.c0_req || bus.c1_req)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = bus.action_done ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.action_done) begin
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_capture    = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !r_cur_we && bus.rd_valid;
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_nxt == ST_RESP);
    // Read data arriving together with action_done still counts as seen
    assign w_rvalid_nxt = w_enter_resp && !r_cur_we && (r_rd_seen || w_capture) && !w_timeout;

    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            r_state       <= ST_IDLE;
            r_cur_id      <= 1'b0;
            r_cur_we      <= 1'b0;
            r_last_id     <= 1'b1;
            r_rd_seen     <= 1'b0;
            r_cnt         <= 16'd0;
            r_c0_gnt      <= 1'b0;
            r_c1_gnt      <= 1'b0;
            r_c0_done     <= 1'b0;
            r_c1_done     <= 1'b0;
            r_c0_rvalid   <= 1'b0;
            r_c1_rvalid   <= 1'b0;
            r_c0_rdata    <= '0;
            r_c1_rdata    <= '0;
            r_wr_rq       <= 1'b0;
            r_rd_rq       <= 1'b0;
            r_wr_adr      <= '0;
            r_rd_adr      <= '0;
            r_wr_data     <= '0;
            r_byte_enable <= '0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_c0_gnt    <= w_grant && !w_win_id;
            r_c1_gnt    <= w_grant &&  w_win_id;
            r_wr_rq     <= w_grant &&  w_win_we;
            r_rd_rq     <= w_grant && !w_win_we;
            r_c0_done   <= w_enter_resp && !r_cur_id;
            r_c1_done   <= w_enter_resp &&  r_cur_id;
            r_c0_rvalid <= w_rvalid_nxt && !r_cur_id;
            r_c1_rvalid <= w_rvalid_nxt &&  r_cur_id;
            r_err       <= w_enter_resp && w_timeout;

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if (w_grant) begin
                r_cur_id      <= w_win_id;
                r_cur_we      <= w_win_we;
                r_wr_adr      <= w_win_addr;
                r_rd_adr      <= w_win_addr;
                r_wr_data     <= w_win_wdata;
                r_byte_enable <= w_win_be;
                r_rd_seen     <= 1'b0;
            end else if (w_capture) begin
                r_rd_seen <= 1'b1;
                if (r_cur_id) begin
                    r_c1_rdata <= bus.rd_data;
                end else begin
                    r_c0_rdata <= bus.rd_data;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= 16'd0;
            end else if ((r_state == ST_WAIT) && !bus.action_done) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_state == ST_RESP) begin
                r_last_id <= r_cur_id;
            end
        end
    end

    assign bus.c0_gnt      = r_c0_gnt;
    assign bus.c1_gnt      = r_c1_gnt;
    assign bus.c0_done     = r_c0_done;
    assign bus.c1_done     = r_c1_done;
    assign bus.c0_rvalid   = r_c0_rvalid;
    assign bus.c1_rvalid   = r_c1_rvalid;
    assign bus.c0_rdata    = r_c0_rdata;
    assign bus.c1_rdata    = r_c1_rdata;
    assign bus.wr_rq       = r_wr_rq;
    assign bus.rd_rq       = r_rd_rq;
    assign bus.wr_adr      = r_wr_adr;
    assign bus.rd_adr      = r_rd_adr;
    assign bus.wr_data     = r_wr_data;
    assign bus.byte_enable = r_byte_enable;
    assign bus.busy        = r_busy;
    assign bus.err         = r_err;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_port_arbiter
// Purpose  : Randomized self-checking bench for ddr_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_port_arbiter;

    localparam int TO = 8;

    logic avalon_clk = 1'b0;
    logic avalon_reset;

    ddr_port_arbiter_if bus();

    ddr_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .avalon_clk   (avalon_clk),
        .avalon_reset (avalon_reset),
        .bus          (bus)
    );

    always #5 avalon_clk = ~avalon_clk;

    typedef struct packed {
        logic         we;
        logic [24:0]  addr;
        logic [255:0] wdata;
        logic [31:0]  be;
    } cmd_t;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           m_last;
    logic         m_terr;
    logic [255:0] m_rdata [2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = 25'($urandom);
        c.wdata = rnd256();
        c.be    = $urandom;
        return c;
    endfunction

    task automatic clear_inputs();
        bus.c0_req = 0; bus.c0_we = 0; bus.c0_addr = '0; bus.c0_wdata = '0; bus.c0_be = '0;
        bus.c1_req = 0; bus.c1_we = 0; bus.c1_addr = '0; bus.c1_wdata = '0; bus.c1_be = '0;
        bus.rd_valid = 0; bus.rd_data = '0; bus.action_done = 0;
    endtask

    task automatic apply_reset();
        @(negedge avalon_clk);
        avalon_reset = 1'b1;
        clear_inputs();
        bus.local_cal_success = 1'b1;
        m_last = 1; m_terr = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
        @(negedge avalon_clk);
        @(negedge avalon_clk);
        avalon_reset = 1'b0;
        @(posedge avalon_clk); #1;
    endtask

    // d: cycle offset from the grant cycle at which action_done is driven
    task automatic do_txn(input logic r0, input logic r1, input cmd_t k0, input cmd_t k1,
                          input int d, input logic give_rv, input int rv_at, input logic [255:0] rvd);
        int   w, e, k;
        logic seen, cap, err_exp;
        cmd_t kw;
        w  = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
        kw = (w == 0) ? k0 : k1;
        @(negedge avalon_clk);
        bus.c0_req = r0; bus.c0_we = k0.we; bus.c0_addr = k0.addr; bus.c0_wdata = k0.wdata; bus.c0_be = k0.be;
        bus.c1_req = r1; bus.c1_we = k1.we; bus.c1_addr = k1.addr; bus.c1_wdata = k1.wdata; bus.c1_be = k1.be;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(posedge avalon_clk); #1; k++;
            seen = bus.c0_gnt | bus.c1_gnt;
        end
        if (!seen) begin
            check("gnt_seen", 256'(0), 256'(1));
            @(negedge avalon_clk); bus.c0_req = 0; bus.c1_req = 0;
            return;
        end
        check("gnt_who", 256'({bus.c1_gnt, bus.c0_gnt}), 256'((w == 0) ? 2'b01 : 2'b10));
        check("rq_kind", 256'({bus.wr_rq, bus.rd_rq}), 256'(kw.we ? 2'b10 : 2'b01));
        check("wr_adr", 256'(bus.wr_adr), 256'(kw.addr));
        check("rd_adr", 256'(bus.rd_adr), 256'(kw.addr));
        check("wr_data", bus.wr_data, kw.wdata);
        check("byte_en", 256'(bus.byte_enable), 256'(kw.be));
        check("busy_gnt", 256'(bus.busy), 256'(1));

        e       = (d <= TO) ? d + 1 : TO + 1;
        err_exp = (d > TO);
        cap     = give_rv && !kw.we && (rv_at < e);
        k = 0; seen = 0;
        while (!seen && k < TO + 10) begin
            @(negedge avalon_clk);
            if (k == 0) begin
                if (w == 0) bus.c0_req = 0; else bus.c1_req = 0;
            end
            bus.action_done = (k == d);
            bus.rd_valid    = give_rv && (k == rv_at);
            bus.rd_data     = bus.rd_valid ? rvd : rnd256();
            @(posedge avalon_clk); #1; k++;
            seen = bus.c0_done | bus.c1_done;
            if (!seen) check("gnt_quiet", 256'({bus.c1_gnt, bus.c0_gnt}), 256'(0));
        end
        if (cap) m_rdata[w] = rvd;
        m_terr = m_terr | err_exp;
        check("done_lat", 256'(k), 256'(e));
        check("done_who", 256'({bus.c1_done, bus.c0_done}), 256'((w == 0) ? 2'b01 : 2'b10));
        check("err", 256'(bus.err), 256'(err_exp));
        check("rvalid", 256'({bus.c1_rvalid, bus.c0_rvalid}),
              256'((cap && !err_exp) ? ((w == 0) ? 2'b01 : 2'b10) : 2'b00));
        check("c0_rdata", bus.c0_rdata, m_rdata[0]);
        check("c1_rdata", bus.c1_rdata, m_rdata[1]);
        check("timeout_err", 256'(bus.timeout_err), 256'(m_terr));
        @(negedge avalon_clk);
        bus.action_done = 0; bus.rd_valid = 0; bus.c0_req = 0; bus.c1_req = 0;
        m_last = w;
        @(posedge avalon_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t a, b;
        int   ng, nd;
        avalon_reset = 1'b1;
        bus.local_cal_success = 1'b1;
        clear_inputs();
        #1;
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_pulses", 256'({bus.c0_gnt, bus.c1_gnt, bus.c0_done, bus.c1_done, bus.wr_rq, bus.rd_rq, bus.err}), 256'(0));
        check("rst_terr", 256'(bus.timeout_err), 256'(0));
        check("rst_rdata", bus.c0_rdata | bus.c1_rdata, 256'(0));
        check("rst_cmd", 256'(bus.wr_adr) | bus.wr_data, 256'(0));
        apply_reset();

        // Contention straight out of reset: order must alternate starting at c0
        for (int i = 0; i < 4; i++) begin
            a = rnd_cmd(); b = rnd_cmd();
            do_txn(1, 1, a, b, $urandom_range(0, 4), 1, 0, rnd256());
        end

        a = '{we: 1'b1, addr: 25'h10, wdata: {32{8'hA5}}, be: 32'hFFFF_FFFF};
        do_txn(1, 0, a, rnd_cmd(), 5, 0, 0, '0);

        b = '{we: 1'b0, addr: 25'h3, wdata: '0, be: 32'hFFFF_FFFF};
        do_txn(0, 1, rnd_cmd(), b, 2, 1, 2, 256'h1234);

        a = '{we: 1'b0, addr: 25'h77, wdata: '0, be: '1};
        do_txn(1, 0, a, rnd_cmd(), 0, 1, 0, rnd256());

        a.addr = 25'h55;
        do_txn(1, 0, a, rnd_cmd(), 1000, 0, 0, '0);
        b = rnd_cmd(); b.we = 1'b0;
        do_txn(0, 1, rnd_cmd(), b, 3, 1, 1, rnd256());
        do_txn(1, 0, rnd_cmd(), rnd_cmd(), 2, 0, 0, '0);

        for (int i = 0; i < 40; i++) begin
            int   d, sel;
            sel = $urandom_range(1, 3);
            d   = $urandom_range(0, 11);
            do_txn(sel[0], sel[1], rnd_cmd(), rnd_cmd(), d, 1'($urandom_range(0, 1)),
                   $urandom_range(0, d), rnd256());
        end

        // Calibration gate, then reset while waiting on the bridge
        apply_reset();
        @(negedge avalon_clk);
        bus.local_cal_success = 0; bus.c0_req = 1; bus.c0_we = 0; bus.c0_addr = 25'h9;
        ng = 0;
        repeat (20) begin
            @(posedge avalon_clk); #1;
            if (bus.c0_gnt | bus.c1_gnt) ng++;
        end
        check("cal_gate", 256'(ng), 256'(0));
        @(negedge avalon_clk);
        bus.local_cal_success = 1;
        @(posedge avalon_clk); #1;
        check("cal_gnt", 256'(bus.c0_gnt), 256'(1));
        @(negedge avalon_clk);
        bus.c0_req = 0;
        @(posedge avalon_clk); #1;
        @(posedge avalon_clk); #1;
        check("busy_wait", 256'(bus.busy), 256'(1));
        @(negedge avalon_clk);
        avalon_reset = 1'b1;
        #1;
        check("rst_async_busy", 256'(bus.busy), 256'(0));
        @(negedge avalon_clk);
        avalon_reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge avalon_clk);
            bus.action_done = (i == 2);
            @(posedge avalon_clk); #1;
            if (bus.c0_done | bus.c1_done | bus.err) nd++;
        end
        bus.action_done = 0;
        check("no_done_after_rst", 256'(nd), 256'(0));
        check("terr_after_rst", 256'(bus.timeout_err), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
